// File: rtl/bch_encoder_if.sv
// Serial bit-stream bundle between message source, encoder and decoder.
// Input side uses valid/ready; the output side is a valid strobe with last.
interface bch_encoder_if;
  logic DATA_IN;
  logic DATA_IN_VALID;
  logic DATA_IN_READY;
  logic DATA_OUT;
  logic DATA_OUT_VALID;
  logic DATA_OUT_LAST;

  modport master (
    output DATA_IN,
    output DATA_IN_VALID,
    input  DATA_IN_READY,
    input  DATA_OUT,
    input  DATA_OUT_VALID,
    input  DATA_OUT_LAST
  );

  modport slave (
    input  DATA_IN,
    input  DATA_IN_VALID,
    output DATA_IN_READY,
    output DATA_OUT,
    output DATA_OUT_VALID,
    output DATA_OUT_LAST
  );
endinterface

// File: rtl/bch_encoder.sv
// Serial systematic cyclic encoder: message bits pass through,
// then the N-K remainder bits of m(x)*x^(N-K) mod g(x), MSB first.
module bch_encoder #(
  parameter int ENC_N = 7,
  parameter int ENC_K = 4,
  parameter logic [ENC_N-ENC_K:0] ENC_BCH_POLYNOM = 4'b1011
) (
  input logic          CLK,
  input logic          RESET,
  bch_encoder_if.slave bus
);

  localparam int R  = ENC_N - ENC_K;
  localparam int DW = $clog2(ENC_K + 1);
  localparam int PW = $clog2(R + 1);
  localparam logic [DW-1:0] D_LAST = DW'(ENC_K - 1);
  localparam logic [PW-1:0] P_LAST = PW'(R - 1);

  typedef enum logic {
    S_DATA,
    S_PARITY
  } state_t;

  state_t        state_q, state_d;
  logic [R-1:0]  lfsr_q, lfsr_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          dout_q, dout_d;
  logic          dval_q, dval_d;
  logic          dlast_q, dlast_d;
  logic          accept;
  logic          fb;

  assign bus.DATA_IN_READY  = (state_q == S_DATA);
  assign bus.DATA_OUT       = dout_q;
  assign bus.DATA_OUT_VALID = dval_q;
  assign bus.DATA_OUT_LAST  = dlast_q;

  assign accept = bus.DATA_IN_VALID && (state_q == S_DATA);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    dcnt_d  = dcnt_q;
    pcnt_d  = pcnt_q;
    dout_d  = dout_q;
    dval_d  = 1'b0;
    dlast_d = 1'b0;
    fb      = 1'b0;
    unique case (state_q)
      S_DATA: begin
        if (accept) begin
          fb        = bus.DATA_IN ^ lfsr_q[R-1];
          lfsr_d[0] = fb & ENC_BCH_POLYNOM[0];
          for (int i = 1; i < R; i++)
            lfsr_d[i] = lfsr_q[i-1]
                      ^ (fb & ENC_BCH_POLYNOM[i]);
          dout_d = bus.DATA_IN;
          dval_d = 1'b1;
          if (dcnt_q == D_LAST) begin
            dcnt_d  = '0;
            state_d = S_PARITY;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        // Remainder drains MSB first; zeros shift in so it ends clear.
        dout_d = lfsr_q[R-1];
        dval_d = 1'b1;
        lfsr_d = lfsr_q << 1;
        if (pcnt_q == P_LAST) begin
          dlast_d = 1'b1;
          pcnt_d  = '0;
          state_d = S_DATA;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      default: state_d = S_DATA;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_DATA;
      lfsr_q  <= '0;
      dcnt_q  <= '0;
      pcnt_q  <= '0;
      dout_q  <= 1'b0;
      dval_q  <= 1'b0;
      dlast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      dcnt_q  <= dcnt_d;
      pcnt_q  <= pcnt_d;
      dout_q  <= dout_d;
      dval_q  <= dval_d;
      dlast_q <= dlast_d;
    end
  end

endmodule

// File: tb/tb_bch_encoder.sv
// Bench for bch_encoder: fixed vectors, corner sequences and a
// randomized loopback through a behavioural single-error decoder.
module tb_bch_encoder;

  localparam int N = 7;
  localparam int K = 4;
  localparam int R = N - K;
  localparam logic [R:0] G = 4'b1011;

  logic CLK = 1'b0;
  logic RESET;
  bch_encoder_if bus ();

  bch_encoder #(
    .ENC_N(N),
    .ENC_K(K),
    .ENC_BCH_POLYNOM(G)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rdy_low = 0;
  bit obits[$];
  bit olast[$];
  int ocyc[$];
  int acyc[$];
  int stray_last = 0;

  always @(negedge CLK) begin
    cyc <= cyc + 1;
    if (!RESET) begin
      if (bus.DATA_OUT_VALID) begin
        obits.push_back(bus.DATA_OUT);
        olast.push_back(bus.DATA_OUT_LAST);
        ocyc.push_back(cyc);
      end else if (bus.DATA_OUT_LAST) begin
        stray_last <= stray_last + 1;
      end
      if (!bus.DATA_IN_READY) rdy_low <= rdy_low + 1;
      if (bus.DATA_IN_READY && bus.DATA_IN_VALID) acyc.push_back(cyc);
    end
  end

  // Reference: polynomial long division over GF(2).
  function automatic logic [R-1:0] poly_rem(input logic [N-1:0] v);
    logic [N-1:0] t;
    logic [N-1:0] gw;
    t  = v;
    gw = N'(G);
    for (int i = N - 1; i >= R; i--)
      if (t[i]) t = t ^ (gw << (i - R));
    return t[R-1:0];
  endfunction

  function automatic logic [N-1:0] encode(input logic [K-1:0] m);
    logic [N-1:0] sh;
    sh = N'(m) << R;
    return sh | N'(poly_rem(sh));
  endfunction

  function automatic logic [K-1:0] decode(input logic [N-1:0] cw);
    logic [R-1:0] syn;
    logic [N-1:0] c;
    logic [N-1:0] e;
    c   = cw;
    syn = poly_rem(c);
    if (syn != '0)
      for (int p = 0; p < N; p++) begin
        e = N'(1) << p;
        if (poly_rem(e) == syn) begin
          c = c ^ e;
          break;
        end
      end
    return c[N-1:R];
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  function automatic logic [N-1:0] got_word(input int w);
    logic [N-1:0] v;
    for (int j = 0; j < N; j++) v[N-1-j] = obits[w*N+j];
    return v;
  endfunction

  function automatic logic [N-1:0] got_last(input int w);
    logic [N-1:0] v;
    for (int j = 0; j < N; j++) v[N-1-j] = olast[w*N+j];
    return v;
  endfunction

  task automatic chk_word(input string nm, input int w,
                          input logic [N-1:0] cw);
    if ((w + 1) * N > obits.size()) begin
      tests++;
      fails++;
      $display("FAIL %s: word missing, got %0d bits need %0d",
               nm, obits.size(), (w + 1) * N);
    end else begin
      chk({nm, " cw"}, int'(got_word(w)), int'(cw));
      chk({nm, " last"}, int'(got_last(w)), 1);
    end
  endtask

  task automatic clear_mon();
    obits.delete();
    olast.delete();
    ocyc.delete();
    acyc.delete();
    rdy_low = 0;
    stray_last = 0;
  endtask

  task automatic idle(input int n);
    bus.DATA_IN_VALID = 1'b0;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    bit rdy;
    bit done;
    done = 0;
    bus.DATA_IN       = b;
    bus.DATA_IN_VALID = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge CLK);
      rdy = bus.DATA_IN_READY;
      @(posedge CLK);
      #1;
      if (rdy) done = 1;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL send_bit: READY never rose within 20 cycles");
    end
  endtask

  task automatic send_word(input logic [K-1:0] m);
    for (int i = K - 1; i >= 0; i--) send_bit(m[i]);
  endtask

  typedef struct {
    logic [K-1:0] msg;
    logic [N-1:0] cw;
  } vec_t;

  vec_t tbl[6];
  logic [K-1:0] rmsg[101];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{4'b1111, 7'b1111111};
    tbl[1] = '{4'b0000, 7'b0000000};
    tbl[2] = '{4'b0100, 7'b0100111};
    tbl[3] = '{4'b0010, 7'b0010110};
    tbl[4] = '{4'b0001, 7'b0001011};
    tbl[5] = '{4'b1010, 7'b1010011};

    bus.DATA_IN       = 1'b0;
    bus.DATA_IN_VALID = 1'b0;
    RESET             = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk_bit("rst dout", bus.DATA_OUT, 1'b0);
    chk_bit("rst valid", bus.DATA_OUT_VALID, 1'b0);
    chk_bit("rst last", bus.DATA_OUT_LAST, 1'b0);
    chk_bit("rst ready", bus.DATA_IN_READY, 1'b1);
    RESET = 1'b0;
    @(posedge CLK);
    #1;

    // Basic word with VALID held through the parity phase.
    clear_mon();
    send_word(4'b1000);
    idle(6);
    chk("w1000 count", obits.size(), N);
    chk_word("w1000", 0, 7'b1000101);
    chk("w1000 ready low", rdy_low, R);
    chk("w1000 stray last", stray_last, 0);
    if (obits.size() == N && acyc.size() == K) begin
      chk("w1000 latency", ocyc[0] - acyc[0], 1);
      chk("w1000 last data", ocyc[K-1] - acyc[K-1], 1);
      chk("w1000 contig", ocyc[N-1] - ocyc[0], N - 1);
    end

    // Table words back-to-back.
    clear_mon();
    foreach (tbl[i]) send_word(tbl[i].msg);
    idle(6);
    chk("tbl count", obits.size(), 6 * N);
    foreach (tbl[i]) chk_word($sformatf("tbl%0d", i), i, tbl[i].cw);
    if (ocyc.size() == 6 * N)
      chk("tbl contig", ocyc[6*N-1] - ocyc[0], 6 * N - 1);
    chk("tbl ready low", rdy_low, 6 * R);

    // Two-cycle input gap after the second message bit.
    clear_mon();
    send_bit(1'b1);
    send_bit(1'b0);
    idle(2);
    send_bit(1'b0);
    send_bit(1'b0);
    idle(6);
    chk_word("gap", 0, 7'b1000101);
    if (ocyc.size() == N) begin
      chk("gap hole", ocyc[2] - ocyc[1], 3);
      chk("gap parity", ocyc[6] - ocyc[3], 3);
    end

    // VALID held with DATA_IN toggling every cycle.
    clear_mon();
    for (int c = 0; c < 11; c++) begin
      bus.DATA_IN       = c[0];
      bus.DATA_IN_VALID = 1'b1;
      @(posedge CLK);
      #1;
    end
    idle(6);
    chk("tog count", obits.size(), 2 * N);
    chk_word("tog0", 0, encode(4'b0101));
    chk_word("tog1", 1, encode(4'b1010));

    // Reset in the middle of a word.
    clear_mon();
    send_bit(1'b1);
    send_bit(1'b1);
    bus.DATA_IN_VALID = 1'b0;
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    chk_bit("mid dout", bus.DATA_OUT, 1'b0);
    chk_bit("mid valid", bus.DATA_OUT_VALID, 1'b0);
    chk_bit("mid last", bus.DATA_OUT_LAST, 1'b0);
    chk_bit("mid ready", bus.DATA_IN_READY, 1'b1);
    RESET = 1'b0;
    clear_mon();
    send_word(4'b1000);
    idle(6);
    chk("mid count", obits.size(), N);
    chk_word("mid", 0, 7'b1000101);

    // Random words with gaps, trailing zero flush word.
    clear_mon();
    for (int w = 0; w < 101; w++) begin
      rmsg[w] = (w == 100) ? '0 : K'($urandom);
      for (int i = K - 1; i >= 0; i--) begin
        send_bit(rmsg[w][i]);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
    end
    idle(8);
    chk("rnd count", obits.size(), 101 * N);
    for (int w = 0; w < 101; w++) begin
      logic [N-1:0] cw;
      int p;
      chk_word($sformatf("rnd%0d", w), w, encode(rmsg[w]));
      if ((w + 1) * N <= obits.size()) begin
        cw = got_word(w);
        p  = $urandom_range(0, N - 1);
        cw[p] = ~cw[p];
        chk($sformatf("rnd%0d dec", w), int'(decode(cw)), int'(rmsg[w]));
      end
    end
    chk("rnd stray last", stray_last, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
